// File: rtl/dualshock_device.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dualshock_device                                              |
// | Function : Controller-side end of the PlayStation pad serial link.       |
// |            Answers the 0x01/0x42 poll with a digital or analog report,   |
// |            pulses ACK between bytes and captures the vibration bytes.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dualshock_device #(
  parameter int ACK_DLY = 250,
  parameter int ACK_LEN = 100
) (
  input  logic        clk,
  input  logic        I_RSTn,
  input  logic        I_psCLK,
  input  logic        I_psSEL,
  input  logic        I_psTXD,
  output logic        O_psRXD,
  output logic        O_psACK,
  input  logic        I_type,
  input  logic [15:0] I_buttons,
  input  logic [31:0] I_stick,
  output logic [7:0]  O_cmd,
  output logic [7:0]  O_vib1,
  output logic [7:0]  O_vib2,
  output logic        O_poll
);

  // One counter serves both the ACK delay and the ACK pulse width.
  localparam int CNT_MAX = (ACK_DLY > ACK_LEN) ? ACK_DLY : ACK_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(ACK_DLY - 1);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(ACK_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_ACKWAIT = 3'd2,
    ST_ACKING  = 3'd3,
    ST_DONE    = 3'd4,
    ST_IGNORE  = 3'd5
  } state_t;

  // Synchronizer and edge-detect stages
  logic sclk_s1, sclk_s2, sclk_d;
  logic sel_s1, sel_s2, sel_d;
  logic txd_s1, txd_s2;

  logic sclk_fall, sclk_rise, sel_fall, sel_rise;

  // Transaction state
  state_t           state;
  logic [3:0]       byte_idx;
  logic [3:0]       next_idx;
  logic [3:0]       last_idx;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_out;
  logic [6:0]       cmd_sr;
  logic [7:0]       rx_byte;
  logic [7:0]       next_resp;
  logic [7:0]       vib_hold;
  logic [CNT_W-1:0] ack_cnt;

  // Inputs frozen at SEL fall so a report is always coherent
  logic        snap_type;
  logic [15:0] snap_buttons;
  logic [31:0] snap_stick;

  // Bring the link pins into the clk domain. The SEL chain resets to the
  // asserted level so that a SEL already held low across reset does not
  // look like a fresh falling edge afterwards.
  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_d  <= 1'b1;
      sel_s1  <= 1'b0;
      sel_s2  <= 1'b0;
      sel_d   <= 1'b0;
      txd_s1  <= 1'b1;
      txd_s2  <= 1'b1;
    end else begin
      sclk_s1 <= I_psCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sel_s1  <= I_psSEL;
      sel_s2  <= sel_s1;
      sel_d   <= sel_s2;
      txd_s1  <= I_psTXD;
      txd_s2  <= txd_s1;
    end
  end

  assign sclk_fall = sclk_d & ~sclk_s2;
  assign sclk_rise = ~sclk_d & sclk_s2;
  assign sel_fall  = sel_d & ~sel_s2;
  assign sel_rise  = ~sel_d & sel_s2;

  // Command byte as it stands once the current TXD bit is shifted in
  assign rx_byte  = {txd_s2, cmd_sr};
  assign next_idx = byte_idx + 4'd1;
  assign last_idx = snap_type ? 4'd8 : 4'd4;

  // Response byte for the slot that follows the current one
  always_comb begin
    next_resp = 8'hFF;
    case (next_idx)
      4'd1:    next_resp = snap_type ? 8'h73 : 8'h41;
      4'd2:    next_resp = 8'h5A;
      4'd3:    next_resp = snap_buttons[7:0];
      4'd4:    next_resp = snap_buttons[15:8];
      4'd5:    next_resp = snap_stick[7:0];
      4'd6:    next_resp = snap_stick[15:8];
      4'd7:    next_resp = snap_stick[23:16];
      4'd8:    next_resp = snap_stick[31:24];
      default: next_resp = 8'hFF;
    endcase
  end

  // Link protocol engine: byte shifting, command decode and ACK timing
  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state        <= ST_IDLE;
      byte_idx     <= 4'd0;
      bit_cnt      <= 3'd0;
      shift_out    <= 8'hFF;
      cmd_sr       <= 7'd0;
      ack_cnt      <= '0;
      vib_hold     <= 8'h00;
      snap_type    <= 1'b0;
      snap_buttons <= 16'hFFFF;
      snap_stick   <= 32'h0000_0000;
      O_psRXD      <= 1'b1;
      O_psACK      <= 1'b1;
      O_poll       <= 1'b0;
      O_cmd        <= 8'h00;
      O_vib1       <= 8'h00;
      O_vib2       <= 8'h00;
    end else begin
      O_poll <= 1'b0;
      if (sel_rise) begin
        // Host released attention: abandon whatever was in progress.
        state    <= ST_IDLE;
        byte_idx <= 4'd0;
        bit_cnt  <= 3'd0;
        ack_cnt  <= '0;
        O_psRXD  <= 1'b1;
        O_psACK  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            O_psRXD <= 1'b1;
            O_psACK <= 1'b1;
            if (sel_fall) begin
              snap_type    <= I_type;
              snap_buttons <= I_buttons;
              snap_stick   <= I_stick;
              byte_idx     <= 4'd0;
              bit_cnt      <= 3'd0;
              ack_cnt      <= '0;
              shift_out    <= 8'hFF;
              state        <= ST_SHIFT;
            end
          end

          ST_SHIFT, ST_ACKWAIT, ST_ACKING: begin
            // ACK timing runs alongside bit servicing; a host that clocks
            // early is still answered.
            if (state == ST_ACKWAIT) begin
              if (ack_cnt == DLY_LAST) begin
                ack_cnt <= '0;
                O_psACK <= 1'b0;
                state   <= ST_ACKING;
              end else begin
                ack_cnt <= ack_cnt + CNT_W'(1);
              end
            end
            if (state == ST_ACKING) begin
              if (ack_cnt == LEN_LAST) begin
                ack_cnt <= '0;
                O_psACK <= 1'b1;
                state   <= ST_SHIFT;
              end else begin
                ack_cnt <= ack_cnt + CNT_W'(1);
              end
            end

            if (sclk_fall) begin
              O_psRXD   <= shift_out[0];
              shift_out <= {1'b1, shift_out[7:1]};
            end

            if (sclk_rise) begin
              cmd_sr  <= rx_byte[7:1];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // Full command byte received; this decision overrides the
                // ACK timer of the previous byte.
                ack_cnt <= '0;
                O_psACK <= 1'b1;
                if (byte_idx == 4'd0 && rx_byte != 8'h01) begin
                  O_psRXD <= 1'b1;
                  state   <= ST_IGNORE;
                end else if (byte_idx == 4'd1 && rx_byte != 8'h42) begin
                  O_cmd   <= rx_byte;
                  O_psRXD <= 1'b1;
                  state   <= ST_IGNORE;
                end else begin
                  if (byte_idx == 4'd1) begin
                    O_cmd <= rx_byte;
                  end
                  if (byte_idx == 4'd3) begin
                    vib_hold <= rx_byte;
                  end
                  if (byte_idx == 4'd4) begin
                    O_vib1 <= vib_hold;
                    O_vib2 <= rx_byte;
                  end
                  if (byte_idx == last_idx) begin
                    O_poll  <= 1'b1;
                    O_psRXD <= 1'b1;
                    state   <= ST_DONE;
                  end else begin
                    byte_idx  <= next_idx;
                    shift_out <= next_resp;
                    state     <= ST_ACKWAIT;
                  end
                end
              end
            end
          end

          ST_DONE, ST_IGNORE: begin
            O_psRXD <= 1'b1;
            O_psACK <= 1'b1;
          end

          default: begin
            state   <= ST_IDLE;
            O_psRXD <= 1'b1;
            O_psACK <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dualshock_device.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dualshock_device                                           |
// | Function : Self-checking bench for dualshock_device. A host model drives |
// |            transactions; expected output changes are derived from the    |
// |            protocol rules and compared against the DUT every cycle.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dualshock_device;

  localparam int ACK_DLY = 12;
  localparam int ACK_LEN = 6;
  localparam int NCYC    = 65536;
  localparam int LAT     = 3;

  logic        clk = 1'b0;
  logic        I_RSTn = 1'b0;
  logic        I_psCLK = 1'b1;
  logic        I_psSEL = 1'b1;
  logic        I_psTXD = 1'b1;
  logic        I_type = 1'b0;
  logic [15:0] I_buttons = 16'hFFFF;
  logic [31:0] I_stick = 32'h0;
  logic        O_psRXD, O_psACK, O_poll;
  logic [7:0]  O_cmd, O_vib1, O_vib2;

  always #5 clk = ~clk;

  dualshock_device #(.ACK_DLY(ACK_DLY), .ACK_LEN(ACK_LEN)) dut (
    .clk(clk), .I_RSTn(I_RSTn), .I_psCLK(I_psCLK), .I_psSEL(I_psSEL),
    .I_psTXD(I_psTXD), .O_psRXD(O_psRXD), .O_psACK(O_psACK),
    .I_type(I_type), .I_buttons(I_buttons), .I_stick(I_stick),
    .O_cmd(O_cmd), .O_vib1(O_vib1), .O_vib2(O_vib2), .O_poll(O_poll)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_falls = 0;
  int poll_cnt  = 0;

  // Expected-value change schedule: signal index, cycle -> new value.
  // 0 rxd, 1 ack, 2 poll, 3 cmd, 4 vib1, 5 vib2
  logic [7:0] ev_val [0:5][0:NCYC-1];
  bit         ev_set [0:5][0:NCYC-1];
  logic [7:0] cur    [0:5];

  logic [7:0] hb  [0:8];
  logic [7:0] rxb [0:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic sched(input int sig, input int t, input logic [7:0] v);
    if (t < NCYC) begin
      ev_set[sig][t] = 1'b1;
      ev_val[sig][t] = v;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison against the scheduled expectations
  initial begin
    bit prev_ack;
    prev_ack = 1'b1;
    cur[0] = 8'h01; cur[1] = 8'h01; cur[2] = 8'h00;
    cur[3] = 8'h00; cur[4] = 8'h00; cur[5] = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < NCYC) begin
        for (int s = 0; s < 6; s++) begin
          if (ev_set[s][cyc]) cur[s] = ev_val[s][cyc];
        end
      end
      check("rxd",  32'(O_psRXD), 32'(cur[0][0]));
      check("ack",  32'(O_psACK), 32'(cur[1][0]));
      check("poll", 32'(O_poll),  32'(cur[2][0]));
      check("cmd",  32'(O_cmd),   32'(cur[3]));
      check("vib1", 32'(O_vib1),  32'(cur[4]));
      check("vib2", 32'(O_vib2),  32'(cur[5]));
      if (prev_ack && !O_psACK) ack_falls++;
      if (O_poll === 1'b1) poll_cnt++;
      prev_ack = O_psACK;
    end
  end

  initial begin
    #640000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // One host transaction. abort_byte/abort_bits: raise SEL after that many
  // rising edges of that byte. rst_byte: pulse reset during the ACK that
  // follows that byte. chg_byte: invert the buttons during that byte.
  task automatic xfer(input logic typ, input logic [15:0] btn, input logic [31:0] stk,
                      input int nb, input int abort_byte, input int abort_bits,
                      input int rst_byte, input int chg_byte);
    logic [7:0] r [0:8];
    logic [7:0] got;
    logic [7:0] hold3;
    int  last, half, k, j;
    bit  alive, aborted;
    r[0] = 8'hFF; r[1] = typ ? 8'h73 : 8'h41; r[2] = 8'h5A;
    r[3] = btn[7:0];  r[4] = btn[15:8];
    r[5] = stk[7:0];  r[6] = stk[15:8]; r[7] = stk[23:16]; r[8] = stk[31:24];
    last  = typ ? 8 : 4;
    half  = $urandom_range(4, 9);
    hold3 = 8'h00;
    alive = 1'b1;
    aborted = 1'b0;
    for (int i = 0; i < 9; i++) rxb[i] = 8'h00;
    @(negedge clk);
    ack_falls = 0;
    poll_cnt  = 0;
    I_type = typ; I_buttons = btn; I_stick = stk;
    tick(2);
    I_psSEL = 1'b0;
    tick(4);
    for (int n = 0; n < nb && !aborted; n++) begin
      got = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (n == abort_byte && b == abort_bits) begin
          aborted = 1'b1;
          break;
        end
        if (n == chg_byte && b == 3) I_buttons = ~btn;
        I_psCLK = 1'b0;
        I_psTXD = hb[n][b];
        if (alive) sched(0, cyc + LAT, {7'd0, r[n][b]});
        tick(half);
        got[b]  = O_psRXD;
        I_psCLK = 1'b1;
        k = cyc;
        if (b == 7 && alive) begin
          if (n == 0 && hb[0] != 8'h01) begin
            alive = 1'b0;
            sched(0, k + LAT, 8'h01);
          end else begin
            if (n == 1) begin
              sched(3, k + LAT, hb[1]);
              if (hb[1] != 8'h42) begin
                alive = 1'b0;
                sched(0, k + LAT, 8'h01);
              end
            end
            if (alive) begin
              if (n == 3) hold3 = hb[3];
              if (n == 4) begin
                sched(4, k + LAT, hold3);
                sched(5, k + LAT, hb[4]);
              end
              if (n == last) begin
                sched(2, k + LAT, 8'h01);
                sched(2, k + LAT + 1, 8'h00);
                sched(0, k + LAT, 8'h01);
                alive = 1'b0;
              end else begin
                sched(1, k + LAT + ACK_DLY, 8'h00);
                sched(1, k + LAT + ACK_DLY + ACK_LEN, 8'h01);
              end
            end
          end
        end
        if (b == 7 && n == rst_byte) begin
          // Land the reset pulse in the middle of the ACK low period.
          tick(ACK_DLY + 5);
          j = cyc;
          I_RSTn = 1'b0;
          for (int t = j + 1; t < j + ACK_DLY + ACK_LEN + 12 && t < NCYC; t++) begin
            for (int s = 0; s < 6; s++) ev_set[s][t] = 1'b0;
          end
          sched(0, j + 1, 8'h01); sched(1, j + 1, 8'h01); sched(2, j + 1, 8'h00);
          sched(3, j + 1, 8'h00); sched(4, j + 1, 8'h00); sched(5, j + 1, 8'h00);
          tick(1);
          I_RSTn = 1'b1;
          alive = 1'b0;
        end
        tick(half);
      end
      rxb[n] = got;
      if (!aborted && n + 1 < nb) tick(ACK_DLY + ACK_LEN + $urandom_range(2, 8));
    end
    if (!aborted) tick(ACK_DLY + ACK_LEN + 6);
    I_psSEL = 1'b1;
    I_psTXD = 1'b1;
    k = cyc;
    sched(0, k + LAT, 8'h01);
    sched(1, k + LAT, 8'h01);
    tick(8);
  endtask

  task automatic set_hb(input logic [71:0] v);
    for (int i = 0; i < 9; i++) hb[i] = v[8*(8-i) +: 8];
  endtask

  initial begin
    logic [15:0] rb;
    logic [31:0] rs;
    logic        rt;
    int          ab, abits;
    tick(3);
    I_RSTn = 1'b1;
    tick(4);

    // Digital poll
    set_hb(72'h01_42_00_00_00_00_00_00_00);
    xfer(1'b0, 16'hFFEF, 32'h0, 5, -1, 0, -1, -1);
    check("dig_rx0", 32'(rxb[0]), 32'hFF);
    check("dig_rx1", 32'(rxb[1]), 32'h41);
    check("dig_rx2", 32'(rxb[2]), 32'h5A);
    check("dig_rx3", 32'(rxb[3]), 32'hEF);
    check("dig_rx4", 32'(rxb[4]), 32'hFF);
    check("dig_acks", ack_falls, 4);
    check("dig_polls", poll_cnt, 1);
    check("dig_cmd", 32'(O_cmd), 32'h42);

    // Analog poll with vibration bytes
    set_hb(72'h01_42_00_12_34_00_00_00_00);
    xfer(1'b1, 16'hFF7E, 32'h80407FC0, 9, -1, 0, -1, -1);
    check("ana_rx1", 32'(rxb[1]), 32'h73);
    check("ana_rx3", 32'(rxb[3]), 32'h7E);
    check("ana_rx5", 32'(rxb[5]), 32'hC0);
    check("ana_rx6", 32'(rxb[6]), 32'h7F);
    check("ana_rx7", 32'(rxb[7]), 32'h40);
    check("ana_rx8", 32'(rxb[8]), 32'h80);
    check("ana_vib1", 32'(O_vib1), 32'h12);
    check("ana_vib2", 32'(O_vib2), 32'h34);
    check("ana_acks", ack_falls, 8);

    // Wrong address byte
    set_hb(72'h81_42_00_00_00_00_00_00_00);
    xfer(1'b0, 16'h0000, 32'h0, 5, -1, 0, -1, -1);
    check("bad_rx0", 32'(rxb[0]), 32'hFF);
    check("bad_rx1", 32'(rxb[1]), 32'hFF);
    check("bad_acks", ack_falls, 0);
    check("bad_polls", poll_cnt, 0);
    check("bad_cmd", 32'(O_cmd), 32'h42);

    // SEL released after 3 bits of byte 2
    set_hb(72'h01_42_00_55_66_00_00_00_00);
    xfer(1'b1, 16'h0F0F, 32'h11223344, 9, 2, 3, -1, -1);
    check("abort_vib1", 32'(O_vib1), 32'h12);
    check("abort_vib2", 32'(O_vib2), 32'h34);
    check("abort_polls", poll_cnt, 0);
    set_hb(72'h01_42_00_00_00_00_00_00_00);
    xfer(1'b0, 16'hA5C3, 32'h0, 5, -1, 0, -1, -1);
    check("clean_rx0", 32'(rxb[0]), 32'hFF);
    check("clean_rx1", 32'(rxb[1]), 32'h41);
    check("clean_rx3", 32'(rxb[3]), 32'hC3);

    // Buttons change mid-transaction
    set_hb(72'h01_42_00_00_00_00_00_00_00);
    xfer(1'b0, 16'h1234, 32'h0, 5, -1, 0, -1, 2);
    check("snap_rx3", 32'(rxb[3]), 32'h34);
    check("snap_rx4", 32'(rxb[4]), 32'h12);
    check("snap_polls", poll_cnt, 1);

    // Reset pulse during ACK
    set_hb(72'h01_42_00_77_88_00_00_00_00);
    xfer(1'b1, 16'h0000, 32'h0, 9, -1, 0, 1, -1);
    check("rst_acks", ack_falls, 2);
    check("rst_polls", poll_cnt, 0);
    check("rst_cmd", 32'(O_cmd), 32'h00);
    check("rst_vib1", 32'(O_vib1), 32'h00);
    check("rst_rx5", 32'(rxb[5]), 32'hFF);

    // Randomized transactions
    for (int t = 0; t < 8; t++) begin
      rt = 1'($urandom_range(0, 1));
      rb = 16'($urandom);
      rs = $urandom;
      for (int i = 0; i < 9; i++) hb[i] = 8'($urandom);
      hb[0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h01;
      hb[1] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h42;
      ab    = -1;
      abits = 0;
      if ($urandom_range(0, 4) == 0) begin
        ab    = $urandom_range(0, rt ? 8 : 4);
        abits = $urandom_range(0, 7);
      end
      xfer(rt, rb, rs, rt ? 9 : 5, ab, abits, -1, -1);
    end

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
